// File: rtl/seq_multiplier_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding.
package seq_multiplier_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_ctrl.sv
// Control for seq_multiplier: FSM, bit counter and registered handshake outputs.
module seq_multiplier_ctrl
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic step,
  output logic last_step
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign accept    = in_valid && in_ready_q;
  assign step      = (state_q == BUSY);
  assign last_step = step && (cnt_q == LAST_CNT);

  // in_ready comes up one cycle after reset release, so it is never high while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= BUSY;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, one multiplier bit per clock, full 2*WIDTH product.
// Define SEQ_MULTIPLIER_SIGNED_EN to honour in_signed (two's complement operands).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic               accept;
  logic               step;
  logic               last_step;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_ext;
  logic [2*WIDTH-1:0] addend;
  logic               sub_step;

  seq_multiplier_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .step      (step),
    .last_step (last_step)
  );

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic signed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signed_q <= 1'b0;
    end else if (accept) begin
      signed_q <= in_signed;
    end
  end

  // The multiplier's top bit carries negative weight in two's complement, hence the final subtract.
  always_comb begin
    mcand_ext = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
    sub_step  = signed_q && last_step;
  end
`else
  logic unused_in_signed;
  assign unused_in_signed = in_signed;

  always_comb begin
    mcand_ext = {{WIDTH{1'b0}}, in_a};
    sub_step  = 1'b0;
  end
`endif

  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    acc_d  = sub_step ? (acc_q - addend) : (acc_q + addend);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (accept) begin
      mcand_q  <= mcand_ext;
      mplier_q <= in_b;
      acc_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  assign out_p = acc_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8), valid for both macro settings.
module tb_seq_multiplier;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  int compared   = 0;
  int mismatched = 0;

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands from a negedge and returns at the negedge after the acceptance edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s);
    int n;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_a      = ~a;
    in_b      = ~b;
    in_signed = ~s;
    check("busy_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Waits for the product, checks latency and value, optionally stalls, then hands off.
  task automatic checkOutput(input string tag, input logic [2*WIDTH-1:0] exp, input int hold);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(WIDTH));
    check({tag, "_product"}, 64'(out_p), 64'(exp));
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_p"}, 64'(out_p), 64'(exp));
        check({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_handoff_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_p", 64'(out_p), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    applyStimulus(8'hFF, 8'hFF, 1'b0);
    checkOutput("umax", 16'hFE01, 0);

    applyStimulus(8'h12, 8'h34, 1'b0);
    checkOutput("u12x34", 16'h03A8, 0);

    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("zero_zero", 16'h0000, 0);

    applyStimulus(8'hAB, 8'h00, 1'b1);
    checkOutput("ab_zero", 16'h0000, 0);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    applyStimulus(8'h80, 8'h80, 1'b1);
    checkOutput("s_m128_m128", 16'h4000, 0);
    applyStimulus(8'hFF, 8'h05, 1'b1);
    checkOutput("s_m1_5", 16'hFFFB, 0);
    applyStimulus(8'h7F, 8'h80, 1'b1);
    checkOutput("s_127_m128", 16'hC080, 0);
    applyStimulus(8'hFE, 8'hFD, 1'b1);
    checkOutput("s_m2_m3", 16'h0006, 0);
    applyStimulus(8'hFE, 8'hFD, 1'b0);
    checkOutput("u_fe_fd", 16'hFB06, 0);
`else
    applyStimulus(8'h80, 8'h80, 1'b1);
    checkOutput("n_80_80", 16'h4000, 0);
    applyStimulus(8'hFF, 8'h05, 1'b1);
    checkOutput("n_ff_05", 16'h04FB, 0);
    applyStimulus(8'h7F, 8'h80, 1'b1);
    checkOutput("n_7f_80", 16'h3F80, 0);
    applyStimulus(8'hFE, 8'hFD, 1'b1);
    checkOutput("n_fe_fd", 16'hFB06, 0);
`endif

    applyStimulus(8'd100, 8'd3, 1'b0);
    checkOutput("backpressure", 16'h012C, 20);

    applyStimulus(8'd3, 8'd7, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midbusy_out_valid", 64'(out_valid), 64'd0);
    check("midbusy_out_p", 64'(out_p), 64'd0);
    check("midbusy_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midbusy_recover_ready", 64'(in_ready), 64'd1);
    applyStimulus(8'd6, 8'd7, 1'b0);
    checkOutput("after_reset", 16'd42, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
